sram_2168_ctrl: RTL and testbench

Synchronous initiator that drives a bank of 2168-type 4K x 4 static RAMs from a clocked request/acknowledge port. It generates address, CE_n, WE_n and data-bus enable with programmable setup, pulse, hold and access wait states. Data and address are held stable whenever WE_n is low, because the chip writes on any address change while WE_n is low. It sits between the bus/MMU logic and the SRAM bank; the bus is split into out/oe/in, and the top level forms the inout.

---
 rtl/sram_2168_ctrl_pkg.sv | 24 ++
 rtl/sram_2168_ctrl_if.sv | 22 ++
 rtl/sram_2168_ctrl.sv | 134 +++++++++++++
 tb/tb_sram_2168_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_2168_ctrl_pkg.sv
// Shared types and constants for the 2168 SRAM initiator and its bench.
package sram_2168_pkg;

  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned NIB_W    = 4;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned WAIT_MIN = 1;
  localparam int unsigned WAIT_MAX = 15;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WSU  = 3'd2,
    ST_WPL  = 3'd3,
    ST_WHD  = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  // Phase counter counts down to zero, so a phase of n cycles loads n-1.
  function automatic logic [CNT_W-1:0] cnt_load(input int unsigned n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/sram_2168_ctrl_if.sv
// Request/acknowledge port between the bus/MMU logic and the SRAM initiator.
interface sram_2168_ctrl_if #(
  parameter int unsigned W = 16
);
  logic          req;
  logic          we;
  logic [11:0]   addr;
  logic [W-1:0]  wdata;
  logic          busy;
  logic          ack;
  logic [W-1:0]  rdata;

  modport master (
    output req, we, addr, wdata,
    input  busy, ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output busy, ack, rdata
  );
endinterface

// File: rtl/sram_2168_ctrl.sv
// Timed read/write sequencer for a bank of 2168 4K x 4 static RAMs.
module sram_2168_ctrl
  import sram_2168_pkg::*;
#(
  parameter int unsigned CHIPS    = 4,
  parameter int unsigned RD_WAIT  = 2,
  parameter int unsigned WR_SETUP = 1,
  parameter int unsigned WR_PULSE = 2,
  parameter int unsigned WR_HOLD  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  sram_2168_ctrl_if.slave          bus,
  output logic [ADDR_W-1:0]        sram_a,
  output logic                     sram_ce_n,
  output logic                     sram_we_n,
  output logic [NIB_W*CHIPS-1:0]   sram_d_out,
  output logic                     sram_d_oe,
  input  logic [NIB_W*CHIPS-1:0]   sram_d_in
);

  localparam int unsigned W = NIB_W * CHIPS;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               ack_q;
  logic [W-1:0]       rdata_q;
  logic [ADDR_W-1:0]  a_q;
  logic               ce_n_q;
  logic               we_n_q;
  logic [W-1:0]       d_out_q;
  logic               d_oe_q;

  // Address and write data are only loaded in IDLE, so they cannot move while WE_n is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      a_q     <= '0;
      ce_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      d_out_q <= '0;
      d_oe_q  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
          if (bus.req) begin
            busy_q <= 1'b1;
            a_q    <= bus.addr;
            ce_n_q <= 1'b0;
            if (bus.we) begin
              d_out_q <= bus.wdata;
              d_oe_q  <= 1'b1;
              cnt_q   <= cnt_load(WR_SETUP);
              state_q <= ST_WSU;
            end else begin
              cnt_q   <= cnt_load(RD_WAIT);
              state_q <= ST_RD;
            end
          end
        end

        ST_RD: begin
          if (cnt_q == '0) begin
            rdata_q <= sram_d_in;
            ce_n_q  <= 1'b1;
            ack_q   <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        ST_WSU: begin
          if (cnt_q == '0) begin
            we_n_q  <= 1'b0;
            cnt_q   <= cnt_load(WR_PULSE);
            state_q <= ST_WPL;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        ST_WPL: begin
          if (cnt_q == '0) begin
            we_n_q  <= 1'b1;
            cnt_q   <= cnt_load(WR_HOLD);
            state_q <= ST_WHD;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        // Bus is released together with CE_n only after the hold time.
        ST_WHD: begin
          if (cnt_q == '0) begin
            ce_n_q  <= 1'b1;
            d_oe_q  <= 1'b0;
            ack_q   <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        ST_DONE: begin
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.ack    = ack_q;
  assign bus.rdata  = rdata_q;
  assign sram_a     = a_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_d_out = d_out_q;
  assign sram_d_oe  = d_oe_q;

endmodule

// File: tb/tb_sram_2168_ctrl.sv
// Scoreboarded bench for sram_2168_ctrl with a behavioural 2168 bank on the shared bus.
module tb_sram_2168_ctrl;
  import sram_2168_pkg::*;

  localparam int unsigned W      = 16;
  localparam int          RD_LAT = 3;
  localparam int          WR_LAT = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [11:0]   sram_a;
  logic          sram_ce_n, sram_we_n, sram_d_oe;
  logic [W-1:0]  sram_d_out, sram_d_in;

  sram_2168_ctrl_if #(.W(W)) bus_if ();

  sram_2168_ctrl #(
    .CHIPS(4), .RD_WAIT(2), .WR_SETUP(1), .WR_PULSE(2), .WR_HOLD(1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus_if.slave),
    .sram_a     (sram_a),
    .sram_ce_n  (sram_ce_n),
    .sram_we_n  (sram_we_n),
    .sram_d_out (sram_d_out),
    .sram_d_oe  (sram_d_oe),
    .sram_d_in  (sram_d_in)
  );

  always #5 clk = ~clk;

  // Four 4-bit chips side by side, modelled as one 16-bit word per address.
  logic [W-1:0] mem [4096];
  logic         mem_init = 1'b0;

  function automatic logic [W-1:0] pat(input logic [11:0] a);
    return {4'hD, a};
  endfunction

  assign sram_d_in = sram_d_oe ? sram_d_out :
                     ((!sram_ce_n && sram_we_n) ? mem[sram_a] : 16'hDEAD);

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= pat(12'(i));
      mem_init <= 1'b1;
    end else if (!sram_ce_n && !sram_we_n) begin
      mem[sram_a] <= sram_d_in;
    end
  end

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] rd;
    int           at_edge;
  } exp_t;
  exp_t sb[$];

  logic [W-1:0] last_rd = '0;

  logic          prev_we_n = 1'b1;
  logic [11:0]   prev_a = '0;
  logic [W-1:0]  prev_d = '0;

  // Monitor: pops the scoreboard on every ack and watches the WE_n-low invariants.
  always @(negedge clk) begin
    if (bus_if.ack) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'(bus_if.ack), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_rdata", 32'(bus_if.rdata), 32'(e.rd));
        chk("ack_cycle", 32'(edge_cnt), 32'(e.at_edge));
      end
    end
    if (!reset && !sram_we_n) begin
      chk("oe_while_we", 32'(sram_d_oe), 32'd1);
      if (!prev_we_n) begin
        chk("a_stable_we", 32'(sram_a), 32'(prev_a));
        chk("d_stable_we", 32'(sram_d_out), 32'(prev_d));
      end
    end
    prev_we_n = sram_we_n;
    prev_a    = sram_a;
    prev_d    = sram_d_out;
  end

  task automatic wait_idle();
    int budget = 0;
    @(posedge clk); #1;
    while ((bus_if.busy || sb.size() != 0) && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    if (budget >= 100) chk("idle_timeout", 32'(budget), 32'd0);
  endtask

  task automatic push_exp(input logic w, input logic [W-1:0] exp_rd);
    exp_t e;
    if (!w) last_rd = exp_rd;
    e.rd      = last_rd;
    e.at_edge = edge_cnt + (w ? WR_LAT : RD_LAT) - 1;
    sb.push_back(e);
  endtask

  // Single-shot request; returns at #1 after the accept edge (start of cycle 1).
  task automatic issue(input logic w, input logic [11:0] a, input logic [W-1:0] d,
                       input logic [W-1:0] exp_rd);
    wait_idle();
    bus_if.req = 1'b1; bus_if.we = w; bus_if.addr = a; bus_if.wdata = d;
    @(posedge clk); #1;
    bus_if.req = 1'b0;
    push_exp(w, exp_rd);
  endtask

  // Per-cycle pin check; bit k-1 of each mask is the value expected in cycle k.
  task automatic trace(input int n, input logic [7:0] we_n_m, input logic [7:0] oe_m,
                       input logic [7:0] ce_n_m);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      chk($sformatf("we_n_c%0d", k), 32'(sram_we_n), 32'(we_n_m[k-1]));
      chk($sformatf("oe_c%0d", k),   32'(sram_d_oe), 32'(oe_m[k-1]));
      chk($sformatf("ce_n_c%0d", k), 32'(sram_ce_n), 32'(ce_n_m[k-1]));
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},  32'(bus_if.busy),  32'd0);
    chk({tag, "_ack"},   32'(bus_if.ack),   32'd0);
    chk({tag, "_a"},     32'(sram_a),       32'd0);
    chk({tag, "_ce_n"},  32'(sram_ce_n),    32'd1);
    chk({tag, "_we_n"},  32'(sram_we_n),    32'd1);
    chk({tag, "_d_out"}, 32'(sram_d_out),   32'd0);
    chk({tag, "_oe"},    32'(sram_d_oe),    32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus_if.req = 1'b0; bus_if.we = 1'b0; bus_if.addr = '0; bus_if.wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    chk("rst_rdata", 32'(bus_if.rdata), 32'd0);
    reset = 1'b0;

    // Default-timing write, then read it back.
    issue(1'b1, 12'h123, 16'hA5C3, '0);
    trace(5, 8'b0001_1001, 8'b0000_1111, 8'b0001_0000);
    issue(1'b0, 12'h123, '0, 16'hA5C3);
    trace(3, 8'b0000_0111, 8'b0000_0000, 8'b0000_0100);
    wait_idle();
    chk("mem_123", 32'(mem[12'h123]), 32'h0000A5C3);

    // Boundary addresses and their neighbours.
    issue(1'b1, 12'h000, 16'h1111, '0);
    issue(1'b1, 12'hFFF, 16'hFFFF, '0);
    issue(1'b0, 12'h000, '0, 16'h1111);
    issue(1'b0, 12'hFFF, '0, 16'hFFFF);
    issue(1'b0, 12'h001, '0, 16'hD001);
    issue(1'b0, 12'hFFE, '0, 16'hDFFE);
    wait_idle();
    chk("mem_ffe", 32'(mem[12'hFFE]), 32'h0000DFFE);
    chk("mem_001", 32'(mem[12'h001]), 32'h0000D001);

    // Reset during the write pulse: no ack, pins released on the next edge.
    wait_idle();
    bus_if.req = 1'b1; bus_if.we = 1'b1; bus_if.addr = 12'h200; bus_if.wdata = 16'h7777;
    @(posedge clk); #1;
    bus_if.req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_we_n_low", 32'(sram_we_n), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_reset_vals("abort");
    repeat (4) @(negedge clk);
    issue(1'b0, 12'h201, '0, 16'hD201);

    // Continuous req with alternating direction: back-to-back at 4 and 6 cycles.
    wait_idle();
    begin
      logic        sw [4];
      logic [11:0] sa [4];
      logic [15:0] sd [4];
      logic [15:0] se [4];
      sw = '{1'b0, 1'b1, 1'b0, 1'b1};
      sa = '{12'h010, 12'h020, 12'h020, 12'h030};
      sd = '{16'h0000, 16'hBEEF, 16'h0000, 16'h1234};
      se = '{16'hD010, 16'h0000, 16'hBEEF, 16'h0000};
      bus_if.req = 1'b1; bus_if.we = sw[0]; bus_if.addr = sa[0]; bus_if.wdata = sd[0];
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        int p;
        p = sw[i] ? WR_LAT + 1 : RD_LAT + 1;
        push_exp(sw[i], se[i]);
        if (i == 3) begin
          bus_if.req = 1'b0;
        end else begin
          bus_if.we = sw[i+1]; bus_if.addr = sa[i+1]; bus_if.wdata = sd[i+1];
          for (int k = 1; k <= p; k++) begin
            @(negedge clk);
            chk($sformatf("stream%0d_busy_c%0d", i, k), 32'(bus_if.busy),
                (k < p) ? 32'd1 : 32'd0);
          end
          @(posedge clk); #1;
        end
      end
    end
    issue(1'b0, 12'h030, '0, 16'h1234);

    wait_idle();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
